// File: rtl/mc_control_hs_if.sv
// Memory and mul/div handshake bundle for the multicycle RV32I controller,
// plus the ALU operation type it drives.

typedef enum logic [1:0] {
  ALUOP_ADD   = 2'd0,
  ALUOP_SUB   = 2'd1,
  ALUOP_RTYPE = 2'd2,
  ALUOP_ITYPE = 2'd3
} aluop_t;

interface mc_control_hs_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;
  logic md_start;
  logic md_done;

  modport master (
    output mem_req, mem_we, md_start,
    input  mem_ready, md_done
  );

  modport slave (
    input  mem_req, mem_we, md_start,
    output mem_ready, md_done
  );
endinterface

// File: rtl/mc_control_hs.sv
// Multicycle RV32I control FSM with memory valid/ready handshake, bus timeout,
// precise traps, optional mul/div wait state and a retire pulse.

module mc_control_hs #(
  parameter int MEM_TIMEOUT = 16,
  parameter bit TRAP_EN     = 1'b1,
  parameter bit MULDIV_EN   = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  mc_control_hs_if.master        bus,
  input  logic [6:0]             instr_opc,
  input  logic [6:0]             instr_funct7,
  input  logic                   instr_bit20,
  output logic                   ctl_iord,
  output logic                   ctl_irwrite,
  output logic                   ctl_regwrite,
  output logic                   ctl_pcwrite,
  output logic                   ctl_pcwritecond,
  output logic [1:0]             ctl_memtoreg,
  output logic [1:0]             ctl_pcsrc,
  output logic [1:0]             ctl_alusrca,
  output logic [2:0]             ctl_alusrcb,
  output aluop_t                 ctl_aluop,
  output logic                   trap_valid,
  output logic [3:0]             trap_cause,
  output logic                   retire
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] CAUSE_IFAULT  = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_BREAK   = 4'd3;
  localparam logic [3:0] CAUSE_LFAULT  = 4'd5;
  localparam logic [3:0] CAUSE_SFAULT  = 4'd7;
  localparam logic [3:0] CAUSE_ECALL   = 4'd11;

  localparam int              CNT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam bit              TMO_EN   = (MEM_TIMEOUT != 0);

  typedef enum logic [4:0] {
    FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WRITE, MEM_WB, EXEC_R, EXEC_I,
    ALU_WB, MULDIV_WAIT, BRANCH, JAL, JALR, LUI, AUIPC, FENCE, TRAP
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       regwrite;
    logic       pcwrite;
    logic       pcwritecond;
    logic [1:0] memtoreg;
    logic [1:0] pcsrc;
    logic [1:0] alusrca;
    logic [2:0] alusrcb;
    aluop_t     aluop;
    logic       retire;
  } ctl_t;

  state_t           state_q, state_d;
  ctl_t             ctl_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       cause_q, cause_d;
  logic             md_start_q;
  logic             trap_q;
  logic             fire, tmo;

  function automatic ctl_t moore(input state_t s);
    ctl_t c;
    c       = '0;
    c.aluop = ALUOP_ADD;
    case (s)
      FETCH:       begin c.mem_req = 1'b1; c.alusrcb = 3'b001; end
      DECODE:      begin c.alusrca = 2'b11; c.alusrcb = 3'b010; end
      MEM_ADDR:    begin c.alusrca = 2'b01; c.alusrcb = 3'b010; end
      MEM_READ:    begin c.mem_req = 1'b1; c.iord = 1'b1; end
      MEM_WRITE:   begin c.mem_req = 1'b1; c.iord = 1'b1; c.mem_we = 1'b1; end
      MEM_WB:      begin c.regwrite = 1'b1; c.memtoreg = 2'b01; c.retire = 1'b1; end
      EXEC_R:      begin c.alusrca = 2'b01; c.alusrcb = 3'b000; c.aluop = ALUOP_RTYPE; end
      EXEC_I:      begin c.alusrca = 2'b01; c.alusrcb = 3'b010; c.aluop = ALUOP_ITYPE; end
      ALU_WB:      begin c.regwrite = 1'b1; c.memtoreg = 2'b00; c.retire = 1'b1; end
      BRANCH: begin
        c.alusrca = 2'b01; c.alusrcb = 3'b000; c.aluop = ALUOP_SUB;
        c.pcwritecond = 1'b1; c.pcsrc = 2'b01; c.retire = 1'b1;
      end
      JAL: begin
        c.pcwrite = 1'b1; c.pcsrc = 2'b01; c.regwrite = 1'b1;
        c.memtoreg = 2'b10; c.retire = 1'b1;
      end
      JALR: begin
        c.alusrca = 2'b01; c.alusrcb = 3'b010; c.pcwrite = 1'b1; c.pcsrc = 2'b00;
        c.regwrite = 1'b1; c.memtoreg = 2'b10; c.retire = 1'b1;
      end
      LUI:         begin c.alusrca = 2'b10; c.alusrcb = 3'b010; end
      AUIPC:       begin c.alusrca = 2'b11; c.alusrcb = 3'b010; end
      FENCE:       c.retire = 1'b1;
      TRAP:        begin c.pcwrite = 1'b1; c.pcsrc = 2'b10; end
      default:     c = '0;
    endcase
    return c;
  endfunction

  function automatic logic is_mem(input state_t s);
    return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
  endfunction

  // A handshake completes only while a request is actually presented; ready wins over timeout.
  assign fire = ctl_q.mem_req && bus.mem_ready;
  assign tmo  = TMO_EN && ctl_q.mem_req && !bus.mem_ready && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cause_d = 4'd0;
    case (state_q)
      FETCH: begin
        if (fire)                 state_d = DECODE;
        else if (tmo && TRAP_EN) begin state_d = TRAP; cause_d = CAUSE_IFAULT; end
      end
      DECODE: begin
        case (instr_opc)
          OPC_LOAD, OPC_STORE: state_d = MEM_ADDR;
          OPC_RTYPE:  state_d = (MULDIV_EN && instr_funct7 == 7'b0000001) ? MULDIV_WAIT : EXEC_R;
          OPC_ITYPE:  state_d = EXEC_I;
          OPC_BRANCH: state_d = BRANCH;
          OPC_JAL:    state_d = JAL;
          OPC_JALR:   state_d = JALR;
          OPC_LUI:    state_d = LUI;
          OPC_AUIPC:  state_d = AUIPC;
          OPC_FENCE:  state_d = FENCE;
          OPC_SYSTEM: begin
            if (TRAP_EN) begin
              state_d = TRAP;
              cause_d = instr_bit20 ? CAUSE_BREAK : CAUSE_ECALL;
            end else begin
              state_d = FETCH;
            end
          end
          default: begin
            if (TRAP_EN) begin state_d = TRAP; cause_d = CAUSE_ILLEGAL; end
            else          state_d = FETCH;
          end
        endcase
      end
      MEM_ADDR:  state_d = (instr_opc == OPC_STORE) ? MEM_WRITE : MEM_READ;
      MEM_READ: begin
        if (fire)                 state_d = MEM_WB;
        else if (tmo && TRAP_EN) begin state_d = TRAP; cause_d = CAUSE_LFAULT; end
      end
      MEM_WRITE: begin
        if (fire)                 state_d = FETCH;
        else if (tmo && TRAP_EN) begin state_d = TRAP; cause_d = CAUSE_SFAULT; end
      end
      EXEC_R, EXEC_I, LUI, AUIPC: state_d = ALU_WB;
      MULDIV_WAIT: if (bus.md_done) state_d = ALU_WB;
      MEM_WB, ALU_WB, BRANCH, JAL, JALR, FENCE, TRAP: state_d = FETCH;
      default:   state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      ctl_q      <= '0;
      cnt_q      <= '0;
      cause_q    <= 4'd0;
      md_start_q <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctl_q      <= moore(state_d);
      md_start_q <= (state_d == MULDIV_WAIT) && (state_q != MULDIV_WAIT);
      trap_q     <= (state_d == TRAP);
      cause_q    <= cause_d;
      if ((state_d != state_q) && is_mem(state_d))
        cnt_q <= '0;
      else if (ctl_q.mem_req && !bus.mem_ready && (cnt_q != CNT_LAST))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.mem_req      = ctl_q.mem_req;
  assign bus.mem_we       = ctl_q.mem_we;
  assign bus.md_start     = md_start_q;
  assign ctl_iord         = ctl_q.iord;
  // IR load and PC+4 happen in the fetch cycle that the memory actually answers.
  assign ctl_irwrite      = (state_q == FETCH) && fire;
  assign ctl_pcwrite      = ctl_q.pcwrite || ((state_q == FETCH) && fire);
  assign ctl_regwrite     = ctl_q.regwrite;
  assign ctl_pcwritecond  = ctl_q.pcwritecond;
  assign ctl_memtoreg     = ctl_q.memtoreg;
  assign ctl_pcsrc        = ctl_q.pcsrc;
  assign ctl_alusrca      = ctl_q.alusrca;
  assign ctl_alusrcb      = ctl_q.alusrcb;
  assign ctl_aluop        = ctl_q.aluop;
  assign trap_valid       = trap_q;
  assign trap_cause       = cause_q;
  assign retire           = ctl_q.retire || ((state_q == MEM_WRITE) && fire);

endmodule

// File: tb/tb_mc_control_hs.sv
// Randomised bench for mc_control_hs: two configurations driven by a memory and
// mul/div responder, checked per instruction against a cycle/event-count model.

module tb_mc_control_hs;

  localparam logic [6:0] OP_L = 7'b0000011, OP_S = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_B = 7'b1100011, OP_J = 7'b1101111;
  localparam logic [6:0] OP_IJ = 7'b1100111, OP_UL = 7'b0110111, OP_UA = 7'b0010111;
  localparam logic [6:0] OP_F = 7'b0001111, OP_E = 7'b1110011;

  // Configuration 0: timeout 4, traps on, mul/div on. Configuration 1: no timeout, traps off, mul/div off.
  localparam int MT_A = 4;
  localparam int MT_B = 0;

  typedef struct {
    int cyc; int ret; int rw; int trp; int cause; int mds;
    int pwc; int irw; int dmem; int tpcsrc; int last_ret; bit hung;
  } stat_t;

  logic clk;
  logic rst;
  logic [6:0] opc [2];
  logic [6:0] f7 [2];
  logic b20 [2];
  logic rdy [2];
  logic mdd [2];

  wire w_req [2], w_we [2], w_iord [2], w_irw [2], w_rw [2], w_pcw [2];
  wire w_pwc [2], w_mds [2], w_trap [2], w_ret [2];
  wire [1:0] w_m2r [2], w_pcsrc [2], w_asa [2], w_alu [2];
  wire [2:0] w_asb [2];
  wire [3:0] w_cause [2];

  logic s_req, s_we, s_iord, s_irw, s_rw, s_pcw, s_pwc, s_mds, s_trap, s_ret;
  logic [1:0] s_m2r, s_pcsrc, s_asa, s_alu;
  logic [2:0] s_asb;
  logic [3:0] s_cause;

  int n_chk;
  int n_pass;

  mc_control_hs_if bus0 ();
  mc_control_hs_if bus1 ();

  assign bus0.mem_ready = rdy[0];
  assign bus0.md_done   = mdd[0];
  assign bus1.mem_ready = rdy[1];
  assign bus1.md_done   = mdd[1];
  assign w_req[0] = bus0.mem_req;
  assign w_we[0]  = bus0.mem_we;
  assign w_mds[0] = bus0.md_start;
  assign w_req[1] = bus1.mem_req;
  assign w_we[1]  = bus1.mem_we;
  assign w_mds[1] = bus1.md_start;

  mc_control_hs #(.MEM_TIMEOUT(MT_A), .TRAP_EN(1'b1), .MULDIV_EN(1'b1)) dut_a (
    .clk(clk), .reset(rst), .bus(bus0.master),
    .instr_opc(opc[0]), .instr_funct7(f7[0]), .instr_bit20(b20[0]),
    .ctl_iord(w_iord[0]), .ctl_irwrite(w_irw[0]), .ctl_regwrite(w_rw[0]),
    .ctl_pcwrite(w_pcw[0]), .ctl_pcwritecond(w_pwc[0]), .ctl_memtoreg(w_m2r[0]),
    .ctl_pcsrc(w_pcsrc[0]), .ctl_alusrca(w_asa[0]), .ctl_alusrcb(w_asb[0]),
    .ctl_aluop(w_alu[0]), .trap_valid(w_trap[0]), .trap_cause(w_cause[0]), .retire(w_ret[0])
  );

  mc_control_hs #(.MEM_TIMEOUT(MT_B), .TRAP_EN(1'b0), .MULDIV_EN(1'b0)) dut_b (
    .clk(clk), .reset(rst), .bus(bus1.master),
    .instr_opc(opc[1]), .instr_funct7(f7[1]), .instr_bit20(b20[1]),
    .ctl_iord(w_iord[1]), .ctl_irwrite(w_irw[1]), .ctl_regwrite(w_rw[1]),
    .ctl_pcwrite(w_pcw[1]), .ctl_pcwritecond(w_pwc[1]), .ctl_memtoreg(w_m2r[1]),
    .ctl_pcsrc(w_pcsrc[1]), .ctl_alusrca(w_asa[1]), .ctl_alusrcb(w_asb[1]),
    .ctl_aluop(w_alu[1]), .trap_valid(w_trap[1]), .trap_cause(w_cause[1]), .retire(w_ret[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  task automatic sample(input int d);
    s_req = w_req[d];   s_we = w_we[d];     s_iord = w_iord[d]; s_irw = w_irw[d];
    s_rw = w_rw[d];     s_pcw = w_pcw[d];   s_pwc = w_pwc[d];   s_mds = w_mds[d];
    s_trap = w_trap[d]; s_ret = w_ret[d];   s_m2r = w_m2r[d];   s_pcsrc = w_pcsrc[d];
    s_asa = w_asa[d];   s_alu = w_alu[d];   s_asb = w_asb[d];   s_cause = w_cause[d];
  endtask

  // Expected per-instruction event counts from the instruction class and the latencies.
  function automatic stat_t model(input int d, input logic [6:0] op, input logic [6:0] fu,
                                  input logic bb, input int flat, input int dlat, input int mlat);
    stat_t e;
    bit te, mde;
    int mt;
    e = '{default: 0};
    te  = (d == 0);
    mde = (d == 0);
    mt  = (d == 0) ? MT_A : MT_B;
    e.cyc = flat + 2;
    e.irw = 1;
    case (op)
      OP_L, OP_S: begin
        e.cyc += 1;
        if (mt != 0 && dlat >= mt) begin
          e.dmem = mt;
          e.cyc += mt + 1;
          e.trp = 1;
          e.cause = (op == OP_L) ? 5 : 7;
        end else begin
          e.dmem = dlat + 1;
          e.cyc += dlat + 1;
          e.ret = 1;
          if (op == OP_L) begin e.cyc += 1; e.rw = 1; end
        end
      end
      OP_R: begin
        if (mde && fu == 7'h01) begin e.cyc += mlat + 2; e.mds = 1; end
        else e.cyc += 2;
        e.rw = 1; e.ret = 1;
      end
      OP_I, OP_UL, OP_UA: begin e.cyc += 2; e.rw = 1; e.ret = 1; end
      OP_B: begin e.cyc += 1; e.ret = 1; e.pwc = 1; end
      OP_J, OP_IJ: begin e.cyc += 1; e.rw = 1; e.ret = 1; end
      OP_F: begin e.cyc += 1; e.ret = 1; end
      OP_E: if (te) begin e.cyc += 1; e.trp = 1; e.cause = bb ? 3 : 11; end
      default: if (te) begin e.cyc += 1; e.trp = 1; e.cause = 2; end
    endcase
    if (e.trp != 0) e.tpcsrc = 2;
    e.last_ret = e.ret;
    return e;
  endfunction

  // Runs one instruction from its first FETCH cycle until the next FETCH begins.
  task automatic run_instr(input int d, input logic [6:0] op, input logic [6:0] fu,
                           input logic bb, input int flat, input int dlat, input int mlat,
                           output stat_t o);
    int acc, mdc;
    bit mda, done;
    o = '{default: 0};
    opc[d] = op; f7[d] = fu; b20[d] = bb;
    acc = 0; mdc = 0; mda = 0; done = 0;
    for (int c = 0; c < 80; c++) begin
      sample(d);
      if (o.irw > 0 && s_req && !s_iord) begin done = 1; break; end
      if (s_mds) begin mda = 1; mdc = 0; end
      mdd[d] = mda && (mdc >= mlat);
      if (mdd[d]) mda = 0;
      else if (mda) mdc++;
      if (s_req) begin
        rdy[d] = (acc >= (s_iord ? dlat : flat));
        acc = rdy[d] ? 0 : acc + 1;
      end else begin
        rdy[d] = 1'b0;
        acc = 0;
      end
      #1;
      sample(d);
      o.cyc++;
      o.ret  += int'(s_ret);
      o.rw   += int'(s_rw);
      o.trp  += int'(s_trap);
      o.mds  += int'(s_mds);
      o.pwc  += int'(s_pwc);
      o.irw  += int'(s_irw);
      if (s_req && s_iord) o.dmem++;
      if (s_trap) begin o.cause = int'(s_cause); o.tpcsrc = int'(s_pcsrc); end
      o.last_ret = int'(s_ret);
      @(posedge clk); #1;
    end
    rdy[d] = 1'b0;
    mdd[d] = 1'b0;
    o.hung = !done;
  endtask

  task automatic run_chk(input int d, input logic [6:0] op, input logic [6:0] fu,
                         input logic bb, input int flat, input int dlat, input int mlat);
    stat_t e, o;
    string p;
    e = model(d, op, fu, bb, flat, dlat, mlat);
    run_instr(d, op, fu, bb, flat, dlat, mlat, o);
    p = $sformatf("cfg%0d op%02h f7%02h", d, op, fu);
    check_eq({p, " finished"}, int'(!o.hung), 1);
    check_eq({p, " cycles"}, o.cyc, e.cyc);
    check_eq({p, " retire"}, o.ret, e.ret);
    check_eq({p, " retire_last"}, o.last_ret, e.last_ret);
    check_eq({p, " regwrite"}, o.rw, e.rw);
    check_eq({p, " trap_valid"}, o.trp, e.trp);
    check_eq({p, " md_start"}, o.mds, e.mds);
    check_eq({p, " pcwritecond"}, o.pwc, e.pwc);
    check_eq({p, " irwrite"}, o.irw, e.irw);
    check_eq({p, " data_req"}, o.dmem, e.dmem);
    if (e.trp != 0) begin
      check_eq({p, " trap_cause"}, o.cause, e.cause);
      check_eq({p, " trap_pcsrc"}, o.tpcsrc, e.tpcsrc);
    end
  endtask

  task automatic do_reset();
    logic any;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      opc[d] = '0; f7[d] = '0; b20[d] = 1'b0; rdy[d] = 1'b0; mdd[d] = 1'b0;
    end
    repeat (2) begin @(posedge clk); #1; end
    for (int d = 0; d < 2; d++) begin
      sample(d);
      any = s_we | s_iord | s_irw | s_rw | s_pcw | s_pwc | s_mds | s_trap | s_ret
          | (|s_m2r) | (|s_pcsrc) | (|s_asa) | (|s_asb) | (|s_cause);
      check_eq($sformatf("cfg%0d reset mem_req", d), int'(s_req), 0);
      check_eq($sformatf("cfg%0d reset outputs", d), int'(any), 0);
      check_eq($sformatf("cfg%0d reset aluop", d), int'(s_alu), 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      sample(d);
      check_eq($sformatf("cfg%0d fetch mem_req", d), int'(s_req), 1);
      check_eq($sformatf("cfg%0d fetch iord", d), int'(s_iord), 0);
      check_eq($sformatf("cfg%0d fetch alusrcb", d), int'(s_asb), 1);
    end
  endtask

  task automatic reset_mid_write();
    int n;
    do_reset();
    opc[0] = OP_S;
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      @(posedge clk); #1;
      sample(0);
      rdy[0] = s_req && !s_iord;
      if (s_req && s_iord && s_we) n++;
    end
    check_eq("rstw reached MEM_WRITE", n, 2);
    rdy[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    sample(0);
    check_eq("rstw mem_req", int'(s_req), 0);
    check_eq("rstw mem_we", int'(s_we), 0);
    check_eq("rstw retire", int'(s_ret), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    sample(0);
    check_eq("rstw fetch req", int'(s_req), 1);
    check_eq("rstw fetch iord", int'(s_iord), 0);
    check_eq("rstw fetch we", int'(s_we), 0);
  endtask

  logic [6:0] op_tab [12];
  logic [6:0] f7_tab [3];

  task automatic random_run(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      run_chk(d, op_tab[$urandom_range(0, 11)], f7_tab[$urandom_range(0, 2)],
              1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
    end
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    op_tab = '{OP_L, OP_S, OP_R, OP_I, OP_B, OP_J, OP_IJ, OP_UL, OP_UA, OP_F, OP_E, 7'h7f};
    f7_tab = '{7'h00, 7'h01, 7'h20};
    do_reset();
    run_chk(0, OP_R, 7'h00, 1'b0, 0, 0, 0);
    run_chk(0, OP_L, 7'h00, 1'b0, 0, 3, 0);
    run_chk(0, OP_S, 7'h00, 1'b0, 0, 99, 0);
    run_chk(0, 7'h00, 7'h00, 1'b0, 1, 0, 0);
    run_chk(0, OP_E, 7'h00, 1'b0, 0, 0, 0);
    run_chk(0, OP_E, 7'h00, 1'b1, 0, 0, 0);
    run_chk(0, OP_R, 7'h01, 1'b0, 0, 0, 5);
    run_chk(0, OP_B, 7'h00, 1'b0, 2, 0, 0);
    reset_mid_write();
    do_reset();
    run_chk(1, 7'h00, 7'h00, 1'b0, 0, 0, 0);
    run_chk(1, OP_E, 7'h00, 1'b0, 0, 0, 0);
    run_chk(1, OP_E, 7'h00, 1'b1, 0, 0, 0);
    run_chk(1, OP_R, 7'h01, 1'b0, 0, 0, 5);
    run_chk(1, OP_S, 7'h00, 1'b0, 1, 5, 0);
    random_run(1, 40);
    do_reset();
    random_run(0, 40);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mc_control_hs.md
Name: mc_control_hs

Overview:
- Parametrised multicycle RV32I control FSM: a successor to the fixed-latency multicycle controller.
- Adds a valid/ready handshake to the unified instruction/data memory, a bus timeout, precise traps (illegal/ECALL/EBREAK/access fault), an optional M-extension wait state and a retire pulse.
- Sits beside the multicycle datapath; drives all of its mux/enable controls. Moore outputs, except the handshake-qualified enables noted below.

Parameters:
- MEM_TIMEOUT, 16: max wait cycles per memory access; 0 = wait forever.
- TRAP_EN, 1: 1 = enter TRAP on faults/illegal; 0 = treat them as NOP and return to FETCH.
- MULDIV_EN, 0: 1 = route OPC_RTYPE with funct7=0000001 to MULDIV_WAIT.

Ports:
- clk in 1: clock.
- reset in 1: synchronous, active-high.
- instr_opc in 7: IR[6:0].
- instr_funct7 in 7: IR[31:25].
- instr_bit20 in 1: IR[20]; 0 = ECALL, 1 = EBREAK.
- mem_ready in 1: memory completes the current request this cycle.
- md_done in 1: mul/div unit result valid.
- mem_req out 1: memory request valid.
- mem_we out 1: write request.
- ctl_iord out 1: 0 = PC address, 1 = ALUOut.
- ctl_irwrite, ctl_regwrite, ctl_pcwrite, ctl_pcwritecond out 1 each.
- ctl_memtoreg out 2: 00 ALUOut, 01 MDR, 10 PC.
- ctl_pcsrc out 2: 00 ALU result, 01 ALUOut, 10 trap vector.
- ctl_alusrca out 2: 00 PC, 01 A, 10 zero, 11 OldPC.
- ctl_alusrcb out 3: 000 B, 001 const 4, 010 imm.
- ctl_aluop out aluop_t: ALU operation.
- md_start out 1: one-cycle mul/div start.
- trap_valid out 1: one-cycle trap commit; the datapath writes mepc/mcause.
- trap_cause out 4: 1 instr access fault, 2 illegal, 3 breakpoint, 5 load fault, 7 store fault, 11 ECALL.
- retire out 1: one-cycle pulse on the last cycle of each completed instruction.

Behaviour:
- Reset: state=FETCH, timeout counter=0. All outputs 0 and ctl_aluop=ALUOP_ADD during and after reset, until the FETCH outputs apply. Reset mid-access drops mem_req the following cycle; no write completes.
- Defaults each cycle: all enables 0, selects 0, ALUOP_ADD.
- FETCH: mem_req=1, iord=0, alusrca=00, alusrcb=001.
  - irwrite and pcwrite (pcsrc=00, PC+4) are asserted only in the cycle mem_ready=1 (Mealy on ready).
  - On ready go to DECODE; otherwise hold.
- DECODE: alusrca=11, alusrcb=010, ADD (branch/JAL target into ALUOut). Dispatch:
  - L/S → MEM_ADDR
  - R → EXEC_R, or MULDIV_WAIT when MULDIV_EN and funct7=0000001
  - I → EXEC_I; B → BRANCH; J → JAL; I_J → JALR
  - U_L → LUI; U_A → AUIPC; F → FENCE
  - E → TRAP (cause 11 or 3) when TRAP_EN, else FETCH
  - anything else → TRAP cause 2 when TRAP_EN, else FETCH
- MEM_ADDR: A+imm. Next MEM_READ (load) or MEM_WRITE (store).
- MEM_READ / MEM_WRITE: mem_req=1, iord=1, mem_we=1 in MEM_WRITE only.
  - Hold until mem_ready.
  - MEM_READ then goes to MEM_WB.
  - MEM_WRITE then goes to FETCH, with retire=1 in the ready cycle.
- MEM_WB: regwrite, memtoreg=01, retire. Next FETCH.
- EXEC_R: A op B, ALUOP_RTYPE. EXEC_I: A op imm, ALUOP_ITYPE. Both go to ALU_WB.
- ALU_WB: regwrite, memtoreg=00, retire. Next FETCH.
- MULDIV_WAIT: md_start=1 on the entry cycle only. Hold until md_done, then ALU_WB.
- BRANCH: A−B, ALUOP_SUB, pcwritecond, pcsrc=01, retire. Next FETCH.
- JAL: pcwrite, pcsrc=01, regwrite, memtoreg=10, retire. Next FETCH.
- JALR: A+imm, pcwrite, pcsrc=00, regwrite, memtoreg=10, retire. Next FETCH.
- LUI: zero+imm. AUIPC: OldPC+imm. Both go to ALU_WB.
- FENCE: retire. Next FETCH.
- Timeout counter:
  - Clears on entry to any memory state; increments each cycle mem_req=1 && !mem_ready.
  - When it reaches MEM_TIMEOUT−1 without ready (MEM_TIMEOUT≠0): TRAP with cause 1/5/7 by state when TRAP_EN; otherwise keep waiting.
  - mem_ready in the same cycle as the timeout wins; the access completes normally.
- TRAP (one cycle): trap_valid=1, trap_cause registered, pcwrite, pcsrc=10, no regwrite, no retire. Next FETCH.
- Unused state encodings go to FETCH.

Test Plan:
- ADD, memory ready every cycle → FETCH, DECODE, EXEC_R, ALU_WB: 4 cycles; regwrite and retire in cycle 4 only.
- LW with mem_ready delayed 3 cycles on the data access → 3 hold cycles with mem_req=1, iord=1; MEM_WB follows; total 8 cycles.
- SW with MEM_TIMEOUT=4 and mem_ready never asserted → trap_valid after 4 MEM_WRITE cycles, trap_cause=7, pcsrc=10, no retire.
- Opcode 0000000 → trap_cause=2. ECALL → 11. EBREAK → 3. With TRAP_EN=0 each returns to FETCH with trap_valid=0.
- MULDIV_EN=1, MUL, md_done after 5 cycles → md_start pulses exactly once, then ALU_WB; with MULDIV_EN=0 the same opcode takes the EXEC_R path.
- Reset asserted in MEM_WRITE while waiting → mem_req/mem_we low the next cycle; state FETCH after reset release.
